// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with optional hardwired zero entry,
// write-first bypass and a sequential clear engine that runs after reset or on request.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear_req,
    output logic                     busy,
    input  logic                     rd_req,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic                     rd_valid,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_done
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t                   state;
    logic [ADDR_W-1:0]        clr_ptr;
    logic [DATA_W-1:0]        regs [DEPTH];
    logic [NUM_RD*DATA_W-1:0] rd_next;
    logic [ADDR_W-1:0]        lane_addr;
    logic                     wr_lands;

    assign busy = (state == CLEAR);

    // wr_done still pulses for a discarded write to the zero entry; only the array update is suppressed.
    always_comb begin
        wr_lands = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
    end

    always_comb begin
        rd_next   = '0;
        lane_addr = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            lane_addr = rd_addr[i*ADDR_W +: ADDR_W];
            if ((ZERO_REG != 0) && (lane_addr == '0))
                rd_next[i*DATA_W +: DATA_W] = '0;
            else if (wr_en && (wr_addr == lane_addr))
                rd_next[i*DATA_W +: DATA_W] = wr_data;
            else
                rd_next[i*DATA_W +: DATA_W] = regs[lane_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= CLEAR;
            clr_ptr  <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            wr_done  <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    regs[clr_ptr] <= '0;
                    clr_ptr       <= clr_ptr + 1'b1;
                    rd_valid      <= 1'b0;
                    wr_done       <= 1'b0;
                    if (clr_ptr == '1)
                        state <= RUN;
                end
                RUN: begin
                    if (clear_req) begin
                        state    <= CLEAR;
                        clr_ptr  <= '0;
                        rd_valid <= 1'b0;
                        wr_done  <= 1'b0;
                    end else begin
                        if (wr_lands)
                            regs[wr_addr] <= wr_data;
                        wr_done  <= wr_en;
                        rd_valid <= rd_req;
                        if (rd_req)
                            rd_data <= rd_next;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    clr_ptr <= '0;
                end
            endcase
        end
    end

endmodule
